// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, frame FSM states and the key event record.
package ps2_pkg;
  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int PS2_EVT_W = 10;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} ps2_state_t;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;
endpackage

// File: rtl/ps2_key_receiver_if.sv
// ps2_key_receiver_if: valid/ready key event stream from receiver to consumer.
interface ps2_key_receiver_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_extended;
  modport master(output evt_valid, evt_code, evt_break, evt_extended, input evt_ready);
  modport slave(input evt_valid, evt_code, evt_break, evt_extended, output evt_ready);
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: show-ahead FIFO; head reads zero when empty, drops pushes when full without a pop.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic                       o_full,
  output logic                       o_drop,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;
  always_comb begin
    o_valid = r_count != '0;
    o_full  = r_count == CW'(DEPTH);
    w_pop   = i_pop & o_valid;
    w_push  = i_push & (~o_full | w_pop);
    o_drop  = i_push & ~w_push;
    o_data  = o_valid ? r_mem[r_rd] : '0;
    o_count = r_count;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: synchronises PS/2 lines, deframes bytes, folds E0/F0 prefixes into key events
// and queues them for a valid/ready consumer.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                            board_clk,
  input  logic                            reset,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            clear_err,
  ps2_key_receiver_if.master              evt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  output logic                            frame_err
);
  localparam int TO_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic                   r_clk_prev;
  ps2_state_t             r_state, w_state_n;
  logic [2:0]             r_bit_cnt, w_bit_cnt_n;
  logic [7:0]             r_shift, w_shift_n;
  logic                   r_par, w_par_n;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_byte_ok, r_ext, r_brk;
  logic                   w_sclk, w_sdata, w_fall, w_timeout, w_good, w_bad;
  logic                   w_is_ext, w_is_brk, w_push, w_drop;
  ps2_evt_t               w_head;
  // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a false fall.
  always_ff @(posedge board_clk)
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_sclk;
    end
  assign w_sclk  = r_clk_sync[SYNC_STAGES-1];
  assign w_sdata = r_data_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_sclk;
  always_comb begin
    w_state_n   = r_state;
    w_bit_cnt_n = r_bit_cnt;
    w_shift_n   = r_shift;
    w_par_n     = r_par;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    w_timeout   = (r_state != S_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES-1));
    if (w_timeout) w_state_n = S_IDLE;
    else if (w_fall)
      case (r_state)
        S_IDLE: begin
          w_state_n   = w_sdata ? S_IDLE : S_DATA;
          w_bit_cnt_n = 3'd0;
        end
        S_DATA: begin
          w_shift_n   = {w_sdata, r_shift[7:1]};
          w_bit_cnt_n = r_bit_cnt + 3'd1;
          w_state_n   = r_bit_cnt == 3'd7 ? S_PARITY : S_DATA;
        end
        S_PARITY: begin
          w_par_n   = w_sdata;
          w_state_n = S_STOP;
        end
        default: begin
          w_good    = w_sdata & (^r_shift ^ r_par);
          w_bad     = ~w_good;
          w_state_n = S_IDLE;
        end
      endcase
  end
  always_ff @(posedge board_clk)
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
      r_byte_ok <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_shift   <= w_shift_n;
      r_par     <= w_par_n;
      r_to_cnt  <= (w_fall || w_timeout || r_state == S_IDLE) ? '0 : r_to_cnt + 1'b1;
      r_byte_ok <= w_good;
    end
  // The decoded byte stays in r_shift during the pulse cycle: only DATA fall cycles shift it.
  assign w_is_ext = r_shift == PS2_EXT_PREFIX;
  assign w_is_brk = r_shift == PS2_BRK_PREFIX;
  assign w_push   = r_byte_ok & ~w_is_ext & ~w_is_brk;
  always_ff @(posedge board_clk)
    if (reset || w_bad || w_timeout) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_byte_ok) begin
      r_ext <= w_is_ext | (w_is_brk & r_ext);
      r_brk <= w_is_brk | (w_is_ext & r_brk);
    end
  always_ff @(posedge board_clk)
    if (reset) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= (frame_err & ~clear_err) | w_bad | w_timeout;
      overflow  <= (overflow & ~clear_err) | w_drop;
    end
  ps2_event_fifo #(.WIDTH(PS2_EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (board_clk),
    .rst    (reset),
    .i_push (w_push),
    .i_data ({r_ext, r_brk, r_shift}),
    .i_pop  (evt.evt_ready),
    .o_data (w_head),
    .o_valid(evt.evt_valid),
    .o_full (),
    .o_drop (w_drop),
    .o_count(fifo_count)
  );
  assign evt.evt_code     = w_head.code;
  assign evt.evt_break    = w_head.brk;
  assign evt.evt_extended = w_head.ext;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: directed frame vectors plus hand-written latency, timeout, overflow and reset sequences.
module tb_ps2_key_receiver;
  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int HALF  = 8;
  logic board_clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, clear_err = 1'b0;
  logic [3:0] fifo_count;
  logic overflow, frame_err;
  int n_tests = 0, n_fail = 0;
  ps2_key_receiver_if evt_if ();
  ps2_key_receiver #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clear_err (clear_err),
    .evt       (evt_if),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );
  always #5 board_clk = ~board_clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end
  typedef struct {
    logic [23:0] bytes;
    int          n;
    bit          bad;
    bit          ev;
    logic [7:0]  code;
    bit          brk;
    bit          ext;
    bit          err;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad);
    return {1'b1, ~^b ^ bad, b, 1'b0};
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge board_clk);
  endtask
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge board_clk);
      ps2_data = f[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input bit bad);
    send_bits(mk(b, bad), 11);
  endtask
  task automatic stop_fall();
    @(negedge board_clk);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
  endtask
  task automatic pop();
    evt_if.evt_ready = 1'b1;
    cyc(1);
    evt_if.evt_ready = 1'b0;
  endtask
  task automatic clr();
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
  endtask
  initial begin
    evt_if.evt_ready = 1'b0;
    vecs[0] = '{24'h00001D, 1, 0, 1, 8'h1D, 0, 0, 0};
    vecs[1] = '{24'h75F0E0, 3, 0, 1, 8'h75, 1, 1, 0};
    vecs[2] = '{24'h000029, 1, 0, 1, 8'h29, 0, 0, 0};
    vecs[3] = '{24'h0012F0, 2, 0, 1, 8'h12, 1, 0, 0};
    vecs[4] = '{24'h006BE0, 2, 0, 1, 8'h6B, 0, 1, 0};
    vecs[5] = '{24'h000076, 1, 1, 0, 8'h00, 0, 0, 1};
    vecs[6] = '{24'h0076E0, 2, 1, 0, 8'h00, 0, 0, 1};
    vecs[7] = '{24'h000076, 1, 0, 1, 8'h76, 0, 0, 0};
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_code", {evt_if.evt_extended, evt_if.evt_break, evt_if.evt_code}, 0);
    chk("rst_flags", {overflow, frame_err}, 0);
    // 0x1D with exact stop-fall to evt_valid latency: 2 sync edges to the fall cycle N, valid in N+2
    send_bits(mk(8'h1D, 0), 10);
    stop_fall();
    cyc(3);
    chk("lat_early", evt_if.evt_valid, 0);
    cyc(1);
    chk("lat_valid", evt_if.evt_valid, 1);
    chk("lat_code", {evt_if.evt_extended, evt_if.evt_break, evt_if.evt_code}, 10'h01D);
    chk("lat_count", fifo_count, 1);
    cyc(HALF);
    ps2_clk = 1'b1;
    pop();
    cyc(1);
    chk("lat_drained", fifo_count, 0);
    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < vecs[v].n; j++)
        send_byte(vecs[v].bytes[j*8 +: 8], vecs[v].bad && j == vecs[v].n - 1);
      cyc(6);
      chk($sformatf("v%0d_count", v), fifo_count, {31'd0, vecs[v].ev});
      chk($sformatf("v%0d_code", v), evt_if.evt_code, vecs[v].code);
      chk($sformatf("v%0d_brk_ext", v), {evt_if.evt_break, evt_if.evt_extended}, {vecs[v].brk, vecs[v].ext});
      chk($sformatf("v%0d_err", v), frame_err, vecs[v].err);
      if (vecs[v].ev) pop();
      clr();
      cyc(1);
      chk($sformatf("v%0d_after", v), {fifo_count, frame_err}, 0);
    end
    // partial frame abandoned by the watchdog
    send_bits(mk(8'h3C, 0), 4);
    cyc(TO / 2);
    chk("to_early", frame_err, 0);
    cyc(TO);
    chk("to_err", frame_err, 1);
    chk("to_count", fifo_count, 0);
    clr();
    send_byte(8'h29, 0);
    cyc(6);
    chk("to_next", {fifo_count, evt_if.evt_extended, evt_if.evt_break, evt_if.evt_code}, {4'd1, 10'h029});
    chk("to_cleared", frame_err, 0);
    pop();
    // fill past capacity with no consumer
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 0);
    cyc(6);
    chk("ovf_count", fifo_count, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", evt_if.evt_code, 8'h01);
    clr();
    chk("ovf_cleared", overflow, 0);
    // 10th push lands in the same cycle (N+1) as a pop
    send_bits(mk(8'h0A, 0), 10);
    stop_fall();
    cyc(3);
    evt_if.evt_ready = 1'b1;
    cyc(1);
    evt_if.evt_ready = 1'b0;
    cyc(1);
    chk("pp_count", fifo_count, DEPTH);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", evt_if.evt_code, 8'h02);
    cyc(HALF);
    ps2_clk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), evt_if.evt_code, i == 7 ? 8'h0A : 8'(i + 2));
      pop();
    end
    evt_if.evt_ready = 1'b1;
    cyc(3);
    evt_if.evt_ready = 1'b0;
    chk("empty_ready", {fifo_count, evt_if.evt_valid, evt_if.evt_code}, 0);
    // reset mid-DATA with an event queued and frame_err set
    send_byte(8'h1D, 0);
    send_byte(8'h44, 1);
    cyc(4);
    chk("pre_rst", {fifo_count, frame_err}, {4'd1, 1'b1});
    send_bits(mk(8'h5A, 0), 5);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_outs", {fifo_count, evt_if.evt_valid, overflow, frame_err}, 0);
    chk("mid_rst_code", {evt_if.evt_extended, evt_if.evt_break, evt_if.evt_code}, 0);
    reset = 1'b0;
    cyc(2);
    send_byte(8'h5A, 0);
    cyc(6);
    chk("post_rst", {fifo_count, evt_if.evt_extended, evt_if.evt_break, evt_if.evt_code}, {4'd1, 10'h05A});
    chk("post_rst_err", frame_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
